// File: rtl/csr_update_regfile_pkg.sv
// Shared constants and types for the CSR update register file.
package csr_regfile_pkg;

  localparam int unsigned REGFILE_SIZE       = 16;
  localparam int unsigned CMD_ZERO_OUT_IDX   = 16;
  localparam int unsigned CMD_WRITE_BACK_IDX = 17;
  localparam int unsigned WB_ADDR_IDX        = 18;
  localparam logic [63:0] CLEAR_MAGIC        = 64'h0000_0000_ACE0_BEEF;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cmd_state_t;

endpackage

// File: rtl/csr_update_regfile_cmd_channel.sv
// One host command channel: req/ack handshake with an optional payload
// captured when the command is raised.
module csr_cmd_channel
  import csr_regfile_pkg::*;
#(
  parameter int unsigned PAYLOAD_W   = 64,
  parameter bit          HAS_PAYLOAD = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_ack,
  input  logic [PAYLOAD_W-1:0] i_payload,
  output logic                 o_req,
  output logic [PAYLOAD_W-1:0] o_payload
);

  cmd_state_t r_state;

  // Handshake FSM: raise on start, drop on the edge that samples ack.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_start) r_state <= PEND;
        PEND:    if (i_ack)   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req = (r_state == PEND);

  if (HAS_PAYLOAD) begin : g_payload
    logic [PAYLOAD_W-1:0] r_payload;

    // Payload is frozen for the whole pending period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_payload <= '0;
      end else if (r_state == IDLE && i_start) begin
        r_payload <= i_payload;
      end
    end

    assign o_payload = r_payload;
  end else begin : g_no_payload
    assign o_payload = '0;
  end

endmodule

// File: rtl/csr_update_regfile.sv
// CSR register file fed by the csr_updater stream: shadow/active banks with
// atomic commit, Avalon-MM host access and req/ack host commands.
module csr_update_regfile
  import csr_regfile_pkg::*;
#(
  parameter int unsigned REGFILE_SIZE = csr_regfile_pkg::REGFILE_SIZE,
  parameter int unsigned ADDR_WIDTH   = $clog2(REGFILE_SIZE) + 1,
  parameter int unsigned AVMM_AW      = 22
) (
  input  logic                  afu_clk,
  input  logic                  afu_rstn,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_addr,
  input  logic [63:0]           update_data,
  input  logic                  avmm_read,
  input  logic                  avmm_write,
  input  logic [AVMM_AW-1:0]    avmm_address,
  input  logic [63:0]           avmm_writedata,
  input  logic [7:0]            avmm_byteenable,
  output logic [63:0]           avmm_readdata,
  output logic                  avmm_readdatavalid,
  output logic                  avmm_waitrequest,
  output logic                  zero_out_req,
  input  logic                  zero_out_ack,
  output logic                  write_back_req,
  input  logic                  write_back_ack,
  output logic [63:0]           write_back_addr,
  output logic                  counters_clear,
  output logic [31:0]           snapshot_seq
);

  localparam int unsigned IDX_W  = AVMM_AW - 3;
  localparam int unsigned WSEL_W = $clog2(REGFILE_SIZE);

  logic [63:0] r_shadow [REGFILE_SIZE];
  logic [63:0] r_active [REGFILE_SIZE];
  logic [63:0] r_wb_addr;
  logic [63:0] r_readdata;
  logic [31:0] r_seq;
  logic        r_rst_done;
  logic        r_upd_prev;
  logic        r_readdatavalid;
  logic        r_counters_clear;

  logic [IDX_W-1:0] w_idx;
  logic [63:0]      w_rd_data;
  logic             w_wait;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_clear;
  logic             w_commit;
  logic             w_beat;
  logic             w_is_zo;
  logic             w_is_wb;
  logic             w_is_wba;
  logic             w_zo_start;
  logic             w_wb_start;
  logic             w_zo_req;
  logic             w_wb_req;
  logic [63:0]      w_wb_payload;

  assign w_idx    = avmm_address[AVMM_AW-1:3];
  assign w_is_zo  = (w_idx == IDX_W'(CMD_ZERO_OUT_IDX));
  assign w_is_wb  = (w_idx == IDX_W'(CMD_WRITE_BACK_IDX));
  assign w_is_wba = (w_idx == IDX_W'(WB_ADDR_IDX));

  // A command write is held off (not dropped) while that command is pending.
  assign w_wait = !r_rst_done ||
                  (avmm_write && ((w_is_zo && w_zo_req) || (w_is_wb && w_wb_req)));

  assign w_wr_acc   = avmm_write && !w_wait;
  assign w_rd_acc   = avmm_read && !avmm_write && !w_wait;
  assign w_clear    = w_wr_acc && (w_idx == '0) &&
                      (avmm_writedata == CLEAR_MAGIC) && (avmm_byteenable == 8'hFF);
  assign w_commit   = r_upd_prev && !update_valid;
  assign w_beat     = update_valid && (update_addr < ADDR_WIDTH'(REGFILE_SIZE));
  assign w_zo_start = w_wr_acc && w_is_zo && (avmm_writedata != '0);
  assign w_wb_start = w_wr_acc && w_is_wb && (avmm_writedata != '0);

  // Reset-release marker; holds waitrequest high until the first edge out of reset.
  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn) r_rst_done <= 1'b0;
    else           r_rst_done <= 1'b1;
  end

  // Track update_valid to detect the end of a burst.
  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn) r_upd_prev <= 1'b0;
    else           r_upd_prev <= update_valid;
  end

  // Shadow fill, atomic commit to active; a clear overrides both on the same edge.
  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn) begin
      for (int unsigned i = 0; i < REGFILE_SIZE; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else if (w_clear) begin
      for (int unsigned i = 0; i < REGFILE_SIZE; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_beat) r_shadow[update_addr[WSEL_W-1:0]] <= update_data;
      if (w_commit) begin
        for (int unsigned i = 0; i < REGFILE_SIZE; i++) r_active[i] <= r_shadow[i];
      end
    end
  end

  // Commit counter; a commit swallowed by a clear is not counted.
  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn)                 r_seq <= '0;
    else if (w_commit && !w_clear) r_seq <= r_seq + 32'd1;
  end

  // One-cycle counter-clear pulse.
  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn) r_counters_clear <= 1'b0;
    else           r_counters_clear <= w_clear;
  end

  // Byte-enabled write-back address register.
  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn) begin
      r_wb_addr <= '0;
    end else if (w_wr_acc && w_is_wba) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (avmm_byteenable[b]) r_wb_addr[8*b +: 8] <= avmm_writedata[8*b +: 8];
      end
    end
  end

  // Read mux by word index.
  always_comb begin
    w_rd_data = '0;
    if (w_idx < IDX_W'(REGFILE_SIZE)) w_rd_data = r_active[w_idx[WSEL_W-1:0]];
    else if (w_is_zo)                 w_rd_data = {63'b0, w_zo_req};
    else if (w_is_wb)                 w_rd_data = {63'b0, w_wb_req};
    else if (w_is_wba)                w_rd_data = r_wb_addr;
  end

  // Registered read response, one cycle after acceptance.
  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdatavalid <= w_rd_acc;
      if (w_rd_acc) r_readdata <= w_rd_data;
    end
  end

  csr_cmd_channel #(
    .PAYLOAD_W   (1),
    .HAS_PAYLOAD (1'b0)
  ) u_zero_out (
    .i_clk     (afu_clk),
    .i_rst_n   (afu_rstn),
    .i_start   (w_zo_start),
    .i_ack     (zero_out_ack),
    .i_payload (1'b0),
    .o_req     (w_zo_req),
    .o_payload ()
  );

  csr_cmd_channel #(
    .PAYLOAD_W   (64),
    .HAS_PAYLOAD (1'b1)
  ) u_write_back (
    .i_clk     (afu_clk),
    .i_rst_n   (afu_rstn),
    .i_start   (w_wb_start),
    .i_ack     (write_back_ack),
    .i_payload (r_wb_addr),
    .o_req     (w_wb_req),
    .o_payload (w_wb_payload)
  );

  assign avmm_readdata      = r_readdata;
  assign avmm_readdatavalid = r_readdatavalid;
  assign avmm_waitrequest   = w_wait;
  assign zero_out_req       = w_zo_req;
  assign write_back_req     = w_wb_req;
  assign write_back_addr    = w_wb_payload;
  assign counters_clear     = r_counters_clear;
  assign snapshot_seq       = r_seq;

endmodule

// File: tb/tb_csr_update_regfile.sv
// Directed self-checking bench for csr_update_regfile.
module tb_csr_update_regfile;

  localparam int unsigned AW = 22;

  logic        afu_clk = 1'b0;
  logic        afu_rstn;
  logic        update_valid;
  logic [4:0]  update_addr;
  logic [63:0] update_data;
  logic        avmm_read;
  logic        avmm_write;
  logic [AW-1:0] avmm_address;
  logic [63:0] avmm_writedata;
  logic [7:0]  avmm_byteenable;
  logic [63:0] avmm_readdata;
  logic        avmm_readdatavalid;
  logic        avmm_waitrequest;
  logic        zero_out_req;
  logic        zero_out_ack;
  logic        write_back_req;
  logic        write_back_ack;
  logic [63:0] write_back_addr;
  logic        counters_clear;
  logic [31:0] snapshot_seq;

  int checks   = 0;
  int failures = 0;

  always #5 afu_clk = ~afu_clk;

  csr_update_regfile #(
    .REGFILE_SIZE (16),
    .ADDR_WIDTH   (5),
    .AVMM_AW      (AW)
  ) dut (
    .afu_clk            (afu_clk),
    .afu_rstn           (afu_rstn),
    .update_valid       (update_valid),
    .update_addr        (update_addr),
    .update_data        (update_data),
    .avmm_read          (avmm_read),
    .avmm_write         (avmm_write),
    .avmm_address       (avmm_address),
    .avmm_writedata     (avmm_writedata),
    .avmm_byteenable    (avmm_byteenable),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .avmm_waitrequest   (avmm_waitrequest),
    .zero_out_req       (zero_out_req),
    .zero_out_ack       (zero_out_ack),
    .write_back_req     (write_back_req),
    .write_back_ack     (write_back_ack),
    .write_back_addr    (write_back_addr),
    .counters_clear     (counters_clear),
    .snapshot_seq       (snapshot_seq)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] waddr(input int unsigned idx);
    waddr = AW'(idx) << 3;
  endfunction

  // Host write; returns after the accepting edge (+1 time unit).
  task automatic wr(input int unsigned idx, input logic [63:0] d, input logic [7:0] be);
    int n;
    @(posedge afu_clk); #1;
    avmm_write = 1'b1; avmm_address = waddr(idx);
    avmm_writedata = d; avmm_byteenable = be;
    n = 0;
    @(negedge afu_clk);
    while (avmm_waitrequest !== 1'b0 && n < 20) begin
      n++;
      @(negedge afu_clk);
    end
    if (n >= 20) chk("wr_timeout", {63'b0, avmm_waitrequest}, 64'd0);
    @(posedge afu_clk); #1;
    avmm_write = 1'b0;
  endtask

  // Host read of one word; checks data and the single-cycle valid.
  task automatic rd_chk(input string tag, input int unsigned idx, input logic [63:0] exp);
    int n;
    @(posedge afu_clk); #1;
    avmm_read = 1'b1; avmm_address = waddr(idx);
    n = 0;
    @(negedge afu_clk);
    while (avmm_waitrequest !== 1'b0 && n < 20) begin
      n++;
      @(negedge afu_clk);
    end
    if (n >= 20) chk("rd_timeout", {63'b0, avmm_waitrequest}, 64'd0);
    @(posedge afu_clk); #1;
    avmm_read = 1'b0;
    @(negedge afu_clk);
    chk({tag, "_valid"}, {63'b0, avmm_readdatavalid}, 64'd1);
    chk(tag, avmm_readdata, exp);
    @(negedge afu_clk);
    chk({tag, "_valid_drop"}, {63'b0, avmm_readdatavalid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    afu_rstn = 1'b0; update_valid = 1'b0; update_addr = '0; update_data = '0;
    avmm_read = 1'b0; avmm_write = 1'b0; avmm_address = '0;
    avmm_writedata = '0; avmm_byteenable = '0;
    zero_out_ack = 1'b0; write_back_ack = 1'b0;

    // 1. reset and release
    repeat (2) @(posedge afu_clk);
    @(negedge afu_clk);
    chk("rst_wait", {63'b0, avmm_waitrequest}, 64'd1);
    chk("rst_rvalid", {63'b0, avmm_readdatavalid}, 64'd0);
    chk("rst_seq", {32'b0, snapshot_seq}, 64'd0);
    chk("rst_zo_req", {63'b0, zero_out_req}, 64'd0);
    chk("rst_wb_req", {63'b0, write_back_req}, 64'd0);
    @(posedge afu_clk); #1;
    afu_rstn = 1'b1;
    @(negedge afu_clk);
    chk("rel_wait_hi", {63'b0, avmm_waitrequest}, 64'd1);
    @(negedge afu_clk);
    chk("rel_wait_lo", {63'b0, avmm_waitrequest}, 64'd0);
    rd_chk("rd5_reset", 5, 64'd0);

    // 2. burst of 16 beats (idx*3) plus two out-of-range beats
    for (int i = 0; i < 18; i++) begin
      @(posedge afu_clk); #1;
      update_valid = 1'b1;
      if (i < 16) begin
        update_addr = 5'(i); update_data = 64'(i * 3);
      end else if (i == 16) begin
        update_addr = 5'd16; update_data = 64'hDEAD;
      end else begin
        update_addr = 5'd31; update_data = 64'hBEEF;
      end
      avmm_read = (i == 8); avmm_address = waddr(7);
      @(negedge afu_clk);
      if (i == 9) begin
        chk("midburst_valid", {63'b0, avmm_readdatavalid}, 64'd1);
        chk("midburst_rd7", avmm_readdata, 64'd0);
      end
    end
    @(posedge afu_clk); #1;
    update_valid = 1'b0;
    avmm_read = 1'b1; avmm_address = waddr(7);
    @(posedge afu_clk); #1;
    avmm_read = 1'b0;
    @(negedge afu_clk);
    chk("commit_cycle_valid", {63'b0, avmm_readdatavalid}, 64'd1);
    chk("commit_cycle_rd7", avmm_readdata, 64'd0);
    chk("seq_after_commit", {32'b0, snapshot_seq}, 64'd1);
    rd_chk("rd7", 7, 64'd21);
    rd_chk("rd15", 15, 64'd45);
    rd_chk("rd0_no_oor", 0, 64'd0);
    rd_chk("rd19", 19, 64'd0);
    rd_chk("rd16_idle", 16, 64'd0);

    // 3. write-back command and address latch
    wr(18, 64'h1000, 8'hFF);
    wr(17, 64'd1, 8'hFF);
    @(negedge afu_clk);
    chk("wb_req_set", {63'b0, write_back_req}, 64'd1);
    chk("wb_addr_latch", write_back_addr, 64'h1000);
    rd_chk("rd17_pend", 17, 64'd1);
    wr(18, 64'h2000, 8'hFF);
    @(negedge afu_clk);
    chk("wb_addr_stable", write_back_addr, 64'h1000);
    wr(18, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
    rd_chk("rd18_be", 18, 64'h20FF);
    @(posedge afu_clk); #1;
    write_back_ack = 1'b1;
    @(negedge afu_clk);
    chk("wb_req_ack_cycle", {63'b0, write_back_req}, 64'd1);
    @(posedge afu_clk); #1;
    write_back_ack = 1'b0;
    @(negedge afu_clk);
    chk("wb_req_drop", {63'b0, write_back_req}, 64'd0);
    // simultaneous read and write: write wins, no read response
    @(posedge afu_clk); #1;
    avmm_read = 1'b1; avmm_write = 1'b1; avmm_address = waddr(18);
    avmm_writedata = 64'h3000; avmm_byteenable = 8'hFF;
    @(posedge afu_clk); #1;
    avmm_read = 1'b0; avmm_write = 1'b0;
    @(negedge afu_clk);
    chk("rw_no_rvalid", {63'b0, avmm_readdatavalid}, 64'd0);
    rd_chk("rd18_rw", 18, 64'h3000);
    // zero-data command write and idle ack have no effect
    wr(16, 64'd0, 8'hFF);
    @(negedge afu_clk);
    chk("zo_zero_data", {63'b0, zero_out_req}, 64'd0);
    @(posedge afu_clk); #1;
    zero_out_ack = 1'b1;
    @(posedge afu_clk); #1;
    zero_out_ack = 1'b0;

    // 4. held command write
    wr(16, 64'd1, 8'hFF);
    @(negedge afu_clk);
    chk("zo_req_set", {63'b0, zero_out_req}, 64'd1);
    @(posedge afu_clk); #1;
    avmm_write = 1'b1; avmm_address = waddr(16);
    avmm_writedata = 64'd1; avmm_byteenable = 8'hFF;
    @(negedge afu_clk);
    chk("hold_wait0", {63'b0, avmm_waitrequest}, 64'd1);
    @(posedge afu_clk); #1;
    zero_out_ack = 1'b1;
    @(negedge afu_clk);
    chk("hold_wait1", {63'b0, avmm_waitrequest}, 64'd1);
    @(posedge afu_clk); #1;
    zero_out_ack = 1'b0;
    @(negedge afu_clk);
    chk("hold_req_drop", {63'b0, zero_out_req}, 64'd0);
    chk("hold_wait_release", {63'b0, avmm_waitrequest}, 64'd0);
    @(posedge afu_clk); #1;
    avmm_write = 1'b0;
    @(negedge afu_clk);
    chk("zo_req_reraise", {63'b0, zero_out_req}, 64'd1);
    wr(17, 64'd5, 8'hFF);
    @(negedge afu_clk);
    chk("both_zo", {63'b0, zero_out_req}, 64'd1);
    chk("both_wb", {63'b0, write_back_req}, 64'd1);
    chk("wb_addr_2", write_back_addr, 64'h3000);
    @(posedge afu_clk); #1;
    zero_out_ack = 1'b1; write_back_ack = 1'b1;
    @(posedge afu_clk); #1;
    zero_out_ack = 1'b0; write_back_ack = 1'b0;
    @(negedge afu_clk);
    chk("both_zo_drop", {63'b0, zero_out_req}, 64'd0);
    chk("both_wb_drop", {63'b0, write_back_req}, 64'd0);

    // 5. clear in the commit cycle
    for (int i = 0; i < 4; i++) begin
      @(posedge afu_clk); #1;
      update_valid = 1'b1; update_addr = 5'(i); update_data = 64'h100 + 64'(i);
    end
    @(posedge afu_clk); #1;
    update_valid = 1'b0;
    avmm_write = 1'b1; avmm_address = waddr(0);
    avmm_writedata = 64'hACE0BEEF; avmm_byteenable = 8'hFF;
    @(negedge afu_clk);
    chk("clr_wait", {63'b0, avmm_waitrequest}, 64'd0);
    @(posedge afu_clk); #1;
    avmm_write = 1'b0;
    @(negedge afu_clk);
    chk("clr_pulse", {63'b0, counters_clear}, 64'd1);
    chk("clr_seq_hold", {32'b0, snapshot_seq}, 64'd1);
    @(negedge afu_clk);
    chk("clr_pulse_end", {63'b0, counters_clear}, 64'd0);
    rd_chk("clr_rd0", 0, 64'd0);
    rd_chk("clr_rd3", 3, 64'd0);
    rd_chk("clr_rd7", 7, 64'd0);
    @(posedge afu_clk); #1;
    update_valid = 1'b1; update_addr = 5'd1; update_data = 64'h77;
    @(posedge afu_clk); #1;
    update_valid = 1'b0;
    @(posedge afu_clk);
    @(negedge afu_clk);
    chk("seq_2", {32'b0, snapshot_seq}, 64'd2);
    rd_chk("post_clr_rd1", 1, 64'h77);
    rd_chk("shadow_clr_rd0", 0, 64'd0);
    rd_chk("shadow_clr_rd7", 7, 64'd0);
    wr(0, 64'hACE0BEEF, 8'h0F);
    @(negedge afu_clk);
    chk("partial_be_no_pulse", {63'b0, counters_clear}, 64'd0);
    rd_chk("partial_be_rd1", 1, 64'h77);

    // 6. reset mid-burst
    for (int i = 0; i < 9; i++) begin
      @(posedge afu_clk); #1;
      update_valid = 1'b1; update_addr = 5'(i); update_data = 64'h55 + 64'(i);
    end
    #2;
    afu_rstn = 1'b0;
    #1;
    chk("mid_rst_wait", {63'b0, avmm_waitrequest}, 64'd1);
    chk("mid_rst_seq", {32'b0, snapshot_seq}, 64'd0);
    chk("mid_rst_wbaddr", write_back_addr, 64'd0);
    update_valid = 1'b0;
    repeat (2) @(posedge afu_clk);
    #1;
    afu_rstn = 1'b1;
    repeat (3) @(posedge afu_clk);
    @(negedge afu_clk);
    chk("post_rst_seq", {32'b0, snapshot_seq}, 64'd0);
    chk("post_rst_wait", {63'b0, avmm_waitrequest}, 64'd0);
    rd_chk("post_rst_rd0", 0, 64'd0);
    rd_chk("post_rst_rd1", 1, 64'd0);
    rd_chk("post_rst_rd8", 8, 64'd0);
    rd_chk("post_rst_rd18", 18, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
